// File: rtl/serial_subtracter.sv
// Multi-cycle two's-complement subtracter: a - b - bin, BITS_PER_CYCLE bits per clock,
// LSB chunk first, with borrow-out, signed-overflow and zero flags.
module serial_subtracter #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned BPC = BITS_PER_CYCLE;
    localparam int unsigned N   = WIDTH / BPC;
    localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH < 2) || (BPC == 0) || ((WIDTH % BPC) != 0)) begin : g_param_check
        $error("serial_subtracter: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [BPC-1:0]   diff_chunk;
    logic             chunk_bout;
    logic             msb_bin;
    logic             last_chunk;
    logic             ai, bi, br;
    int unsigned      base;

    assign base       = 32'(cnt_q) * BPC;
    assign last_chunk = (cnt_q == CW'(N - 1));

    // BPC-stage full-subtracter ripple over the current chunk
    always_comb begin
        diff_chunk = '0;
        br         = brw_q;
        msb_bin    = 1'b0;
        ai         = 1'b0;
        bi         = 1'b0;
        for (int k = 0; k < int'(BPC); k++) begin
            msb_bin       = br;
            ai            = a_q[base + 32'(k)];
            bi            = b_q[base + 32'(k)];
            diff_chunk[k] = ai ^ bi ^ br;
            br            = (~ai & bi) | (~(ai ^ bi) & br);
        end
        chunk_bout = br;
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                d_d[base +: BPC] = diff_chunk;
                brw_d            = chunk_bout;
                cnt_d            = cnt_q + CW'(1);
                if (last_chunk) begin
                    // on the last chunk the final stage is bit WIDTH-1
                    bout_d  = chunk_bout;
                    ovf_d   = msb_bin ^ chunk_bout;
                    zero_d  = (d_d == '0);
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign d         = d_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_subtracter.sv
// Scoreboard bench for serial_subtracter at BITS_PER_CYCLE = 1, 4 and 8 (WIDTH = 8).
module tb_serial_subtracter;

    typedef struct {
        logic [7:0] d;
        logic       bout;
        logic       ovf;
        logic       zero;
        int         acc;
        int         n;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid  [3];
    logic       in_ready  [3];
    logic [7:0] a_i       [3];
    logic [7:0] b_i       [3];
    logic       bin_i     [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic [7:0] d_o       [3];
    logic       bout_o    [3];
    logic       ovf_o     [3];
    logic       zero_o    [3];

    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic prev0  = 1'b0;
    logic prev1  = 1'b0;
    logic prev2  = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtracter #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_bpc1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_i[0]), .b(b_i[0]), .bin(bin_i[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .d(d_o[0]), .bout(bout_o[0]), .ovf(ovf_o[0]), .zero(zero_o[0])
    );
    serial_subtracter #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_bpc4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_i[1]), .b(b_i[1]), .bin(bin_i[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .d(d_o[1]), .bout(bout_o[1]), .ovf(ovf_o[1]), .zero(zero_o[1])
    );
    serial_subtracter #(.WIDTH(8), .BITS_PER_CYCLE(8)) u_bpc8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a_i[2]), .b(b_i[2]), .bin(bin_i[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .d(d_o[2]), .bout(bout_o[2]), .ovf(ovf_o[2]), .zero(zero_o[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Monitor: pop and compare whenever a DUT raises out_valid
    task automatic mon_step(input int k, input logic prev);
        exp_t e;
        if (out_valid[k] && !prev) begin
            if (qsize(k) == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out_valid dut%0d: got out_valid=1, required no result pending", k);
            end else begin
                case (k)
                    0:       e = q0.pop_front();
                    1:       e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                check($sformatf("d dut%0d", k),       32'(d_o[k]),      32'(e.d));
                check($sformatf("bout dut%0d", k),    32'(bout_o[k]),   32'(e.bout));
                check($sformatf("ovf dut%0d", k),     32'(ovf_o[k]),    32'(e.ovf));
                check($sformatf("zero dut%0d", k),    32'(zero_o[k]),   32'(e.zero));
                check($sformatf("latency dut%0d", k), 32'(cyc - e.acc), 32'(e.n));
            end
        end
    endtask

    always @(negedge clk) begin mon_step(0, prev0); prev0 = out_valid[0]; end
    always @(negedge clk) begin mon_step(1, prev1); prev1 = out_valid[1]; end
    always @(negedge clk) begin mon_step(2, prev2); prev2 = out_valid[2]; end

    task automatic issue(input int k, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                         input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
        exp_t e;
        int   g;
        @(negedge clk);
        g = 0;
        while (!in_ready[k] && g < 50) begin
            @(negedge clk);
            g++;
        end
        check($sformatf("in_ready_before_issue dut%0d", k), 32'(in_ready[k]), 32'd1);
        in_valid[k] = 1'b1;
        a_i[k]      = av;
        b_i[k]      = bv;
        bin_i[k]    = bi;
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        e = '{d: ed, bout: eb, ovf: eo, zero: ez, acc: cyc,
              n: (k == 0) ? 8 : ((k == 1) ? 2 : 1)};
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic wait_done(input int k);
        int g;
        g = 0;
        while (qsize(k) != 0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (qsize(k) != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout dut%0d: got no out_valid within 40 cycles, required a result", k);
            case (k)
                0:       q0.delete();
                1:       q1.delete();
                default: q2.delete();
            endcase
        end
        @(negedge clk);
    endtask

    initial begin
        int g;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            a_i[k]       = 8'h00;
            b_i[k]       = 8'h00;
            bin_i[k]     = 1'b0;
            out_ready[k] = 1'b1;
        end
        #2;
        check("reset in_ready",  32'(in_ready[0]),  32'd1);
        check("reset out_valid", 32'(out_valid[0]), 32'd0);
        check("reset d",         32'(d_o[0]),       32'd0);
        check("reset bout",      32'(bout_o[0]),    32'd0);
        check("reset ovf",       32'(ovf_o[0]),     32'd0);
        check("reset zero",      32'(zero_o[0]),    32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // directed vectors, one bit per cycle
        issue(0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0); wait_done(0);
        issue(0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0); wait_done(0);
        issue(0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0); wait_done(0);
        issue(0, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1); wait_done(0);
        issue(0, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0); wait_done(0);
        issue(0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0); wait_done(0);

        // backpressure: DONE holds while inputs toggle
        out_ready[0] = 1'b0;
        issue(0, 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1, 1'b0);
        g = 0;
        while (!out_valid[0] && g < 30) begin
            @(negedge clk);
            g++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid[0] = ~in_valid[0];
            a_i[0]      = a_i[0] + 8'h11;
            b_i[0]      = ~b_i[0];
            check("bp d",         32'(d_o[0]),       32'h4B);
            check("bp bout",      32'(bout_o[0]),    32'd0);
            check("bp ovf",       32'(ovf_o[0]),     32'd1);
            check("bp zero",      32'(zero_o[0]),    32'd0);
            check("bp in_ready",  32'(in_ready[0]),  32'd0);
            check("bp out_valid", 32'(out_valid[0]), 32'd1);
        end
        @(negedge clk);
        check("bp hold d", 32'(d_o[0]), 32'h4B);
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b0;
        @(negedge clk);
        check("bp release out_valid", 32'(out_valid[0]), 32'd0);
        check("bp release in_ready",  32'(in_ready[0]),  32'd1);
        wait_done(0);

        // asynchronous reset during RUN discards the result
        issue(0, 8'h12, 8'h34, 1'b0, 8'hDE, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        q0.delete();
        check("midrun reset in_ready",  32'(in_ready[0]),  32'd1);
        check("midrun reset out_valid", 32'(out_valid[0]), 32'd0);
        check("midrun reset d",         32'(d_o[0]),       32'd0);
        check("midrun reset bout",      32'(bout_o[0]),    32'd0);
        check("midrun reset ovf",       32'(ovf_o[0]),     32'd0);
        check("midrun reset zero",      32'(zero_o[0]),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post reset out_valid", 32'(out_valid[0]), 32'd0);
        issue(0, 8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0); wait_done(0);

        // four bits per cycle
        issue(1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0); wait_done(1);
        issue(1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0); wait_done(1);
        issue(1, 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1, 1'b0); wait_done(1);

        // whole word in one cycle
        issue(2, 8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1); wait_done(2);
        issue(2, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0); wait_done(2);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_subtracter.md
# serial_subtracter

Multi-cycle, parametrised two's-complement subtracter built around the team's full-subtracter cell chain. It computes `a - b - bin` over `WIDTH` bits, `BITS_PER_CYCLE` bits per clock, LSB chunk first, with a registered inter-chunk borrow. It sits in the datapath wherever area matters more than latency, with valid/ready handshakes on input and output. It also produces borrow-out, signed-overflow and zero flags.

## Interface
- `WIDTH`, default 8, operand/result width in bits. Must be ≥ 2.
- `BITS_PER_CYCLE`, default 1, bits processed per RUN cycle. Must divide `WIDTH`. Define `N = WIDTH / BITS_PER_CYCLE`.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operands and `bin` are valid.
- `in_ready`  output  1  block can accept operands (high only in IDLE).
- `a`  input  WIDTH  minuend.
- `b`  input  WIDTH  subtrahend.
- `bin`  input  1  initial borrow-in.
- `out_valid`  output  1  result is valid (high only in DONE).
- `out_ready`  input  1  consumer takes the result.
- `d`  output  WIDTH  difference, `a - b - bin` mod 2^WIDTH.
- `bout`  output  1  final borrow-out (1 when unsigned `a < b + bin`).
- `ovf`  output  1  signed overflow: borrow into MSB XOR borrow out of MSB.
- `zero`  output  1  `d == 0`.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE**
  - `in_ready = 1`.
  - On `in_valid & in_ready`: latch `a`, `b`; load the borrow register with `bin`; clear the chunk counter; go to RUN.
- **RUN**, once per cycle:
  - Take chunk `i` (bits `[i*BPC +: BPC]`) of `a` and `b`.
  - Ripple the chunk through `BPC` full-subtracter stages, starting from the borrow register.
  - Write the difference bits into `d[i*BPC +: BPC]`.
  - Store the chunk's borrow-out in the borrow register.
- **End of RUN:** on the last chunk (`i = N-1`), also capture:
  - `ovf` = (borrow into bit WIDTH-1) XOR (borrow out of bit WIDTH-1);
  - `bout` = borrow out of bit WIDTH-1;
  - `zero` from the completed `d`.
  - Then go to DONE.
- **DONE**
  - `out_valid = 1`. `d`, `bout`, `ovf`, `zero` are held stable.
  - On `out_ready`: go to IDLE.
  - No same-cycle accept of new operands: `in_ready = 0` in DONE.
- **Input handling outside IDLE:** `in_valid` is ignored in RUN and DONE, and operand inputs may change freely there.
- **Reset mid-operation (RUN or DONE):** asynchronously returns to IDLE and clears all registers. The in-flight result is discarded with no `out_valid` pulse.
- **Reset values:** `in_ready = 1`, `out_valid = 0`, `d = 0`, `bout = 0`, `ovf = 0`, `zero = 0`. Internal borrow and counter are 0.
- **Result outputs:** `d`/flags are registered. Their values are only meaningful while `out_valid = 1`; they keep their last values in IDLE until the next computation overwrites `d`.
- **Parameter checks:** illegal parameters (`WIDTH % BITS_PER_CYCLE != 0`, `WIDTH < 2`) are rejected by an elaboration-time check.

## Timing
- Accept at edge E0. RUN occupies edges E1..EN, and `out_valid` rises after edge EN.
  - Latency is N cycles from the accept edge.
  - WIDTH=8: BPC=1 gives 8 cycles; BPC=4 gives 2 cycles; BPC=8 gives 1 cycle.
- `out_ready` held high: DONE lasts one cycle and IDLE is re-entered after EN+1. The next accept can occur at EN+2, so the best-case issue interval is N+2 cycles.
- `out_ready` low: DONE persists indefinitely and outputs stay constant.
- Combinational paths:
  - `in_ready` and `out_valid` are decoded from state only; there is no combinational path from inputs to these outputs.
  - The critical path is one BPC-bit borrow ripple.

## Test plan
- **Basic subtraction** (WIDTH=8, BPC=1): `a=0x05, b=0x03, bin=0` → `d=0x02, bout=0, ovf=0, zero=0`; `out_valid` first sampled high 8 cycles after the accept edge.
- **Borrow out:** `a=0x03, b=0x05, bin=0` → `d=0xFE, bout=1, ovf=0, zero=0`.
- **Signed overflow:** `a=0x80, b=0x01` → `d=0x7F, bout=0, ovf=1`.
- **Borrow-in and zero:** `a=0x10, b=0x0F, bin=1` → `d=0x00, zero=1, bout=0`.
- **Backpressure:** hold `out_ready=0` for 5 cycles while toggling `in_valid`/`a`/`b` → `d`/flags unchanged, `in_ready=0`, and no new accept. Raise `out_ready` → IDLE next cycle.
- **Reset and chunk width:** assert `rst_n=0` at cycle 3 of RUN → immediately IDLE and all outputs 0, with no `out_valid`. Re-run with BPC=4: `a=0x00, b=0x01` → `d=0xFF, bout=1`, latency 2.
